// File: rtl/rtmq_input_sr_pkg.sv
// ============================================================================
//  Module   : rtmq_input_sr_pkg
//  Purpose  : Shared RTMQ bus geometry, command/status bit map and state
//             encoding for the wide-word input shift register peripheral.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rtmq_input_sr_pkg;

   // ALU bus geometry: {wen, addr[c_W_ADR-1:0], data[c_W_REG-1:0]}
   localparam int c_W_REG       = 32;
   localparam int c_W_ADR       = 8;
   localparam int c_W_ALU       = c_W_REG + c_W_ADR + 1;
   localparam int c_ALU_DAT_LSB = 0;
   localparam int c_ALU_ADR_LSB = c_W_REG;
   localparam int c_ALU_WEN_BIT = c_W_REG + c_W_ADR;

   // Command word bits (shared with the firmware header)
   localparam int c_CMD_POP     = 0;
   localparam int c_CMD_FLUSH   = 1;
   localparam int c_CMD_CLR_OVF = 2;
   localparam int c_W_CMD_USED  = 3;

   // Status word layout
   localparam int c_W_CNT       = 8;
   localparam int c_STS_EMPTY   = 8;
   localparam int c_STS_OVF     = 9;

   typedef enum logic [0:0] {
      ST_EMPTY  = 1'b0,
      ST_LOADED = 1'b1
   } isr_state_t;

   // Assemble the CPU-visible status word; unused bits read as zero.
   function automatic logic [c_W_REG-1:0] pack_status(
      input logic [c_W_CNT-1:0] cnt,
      input logic               empty,
      input logic               ovf
   );
      logic [c_W_REG-1:0] s;
      s                = '0;
      s[c_W_CNT-1:0]   = cnt;
      s[c_STS_EMPTY]   = empty;
      s[c_STS_OVF]     = ovf;
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rtmq_input_sr_gpreg.sv
// ============================================================================
//  Module   : rtmq_input_sr_gpreg
//  Purpose  : General-purpose command register on the RTMQ ALU bus. Latches
//             the data field of a write to ADDR and raises a one-cycle trigger.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rtmq_input_sr_gpreg
   import rtmq_input_sr_pkg::*;
#(
   parameter int ADDR = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [c_W_ALU-1:0] alu_out,
   output logic [c_W_REG-1:0] cmd,
   output logic               f_trg
);

   logic               w_hit;
   logic [c_W_REG-1:0] r_cmd;
   logic               r_trg;

   assign w_hit = alu_out[c_ALU_WEN_BIT] &&
                  (alu_out[c_ALU_ADR_LSB +: c_W_ADR] == c_W_ADR'(ADDR));

   // Latch the command word on an addressed write and pulse the trigger once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd <= '0;
         r_trg <= 1'b0;
      end else begin
         r_trg <= w_hit;
         if (w_hit) begin
            r_cmd <= alu_out[c_ALU_DAT_LSB +: c_W_REG];
         end
      end
   end

   assign cmd   = r_cmd;
   assign f_trg = r_trg;

endmodule

`default_nettype wire

// File: rtl/rtmq_input_sr.sv
// ============================================================================
//  Module   : rtmq_input_sr
//  Purpose  : Wide-word input shift register. Captures an N_SRL-word parallel
//             word from fabric over valid/ready and hands it to the CPU one
//             word at a time, least-significant word first.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rtmq_input_sr
   import rtmq_input_sr_pkg::*;
#(
   parameter int ADDR  = 0,
   parameter int N_SRL = 6          // legal range 1..255
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [c_W_ALU-1:0]         alu_out,
   input  logic [c_W_REG*N_SRL-1:0]   dat_inp,
   input  logic                       dat_vld,
   output logic                       dat_rdy,
   output logic [c_W_REG-1:0]         reg_out,
   output logic [c_W_REG-1:0]         sts_out
);

   localparam int               c_W_ISR = c_W_REG * N_SRL;
   localparam logic [c_W_CNT-1:0] c_N_CNT = c_W_CNT'(N_SRL);

   logic [c_W_REG-1:0] w_cmd;
   logic               w_trg;
   logic               w_pop;
   logic               w_flush;
   logic               w_clr;
   logic               w_cmd_unused;
   logic [c_W_ISR-1:0] w_sr_shift;

   isr_state_t         r_state;
   logic [c_W_ISR-1:0] r_sr;
   logic [c_W_CNT-1:0] r_cnt;
   logic               r_rdy;
   logic               r_ovf;

   rtmq_input_sr_gpreg #(
      .ADDR    (ADDR)
   ) u_cmd (
      .clk     (clk),
      .rst_n   (rst_n),
      .alu_out (alu_out),
      .cmd     (w_cmd),
      .f_trg   (w_trg)
   );

   assign w_pop   = w_trg & w_cmd[c_CMD_POP];
   assign w_flush = w_trg & w_cmd[c_CMD_FLUSH];
   assign w_clr   = w_trg & w_cmd[c_CMD_CLR_OVF];

   // Upper command bits are reserved and deliberately ignored
   assign w_cmd_unused = ^w_cmd[c_W_REG-1:c_W_CMD_USED];

   // A single-word register has nothing to shift down
   generate
      if (N_SRL > 1) begin : g_multi
         assign w_sr_shift = {{c_W_REG{1'b0}}, r_sr[c_W_ISR-1:c_W_REG]};
      end else begin : g_single
         assign w_sr_shift = '0;
      end
   endgenerate

   // Capture/pop/flush state machine; in EMPTY a capture takes precedence
   // because a flush of an already empty register has nothing to discard
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_sr    <= '0;
         r_cnt   <= '0;
         r_rdy   <= 1'b1;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (dat_vld) begin
                  r_sr    <= dat_inp;
                  r_cnt   <= c_N_CNT;
                  r_rdy   <= 1'b0;
                  r_state <= ST_LOADED;
               end
            end
            ST_LOADED: begin
               if (w_flush || (w_pop && (r_cnt == c_W_CNT'(1)))) begin
                  r_sr    <= '0;
                  r_cnt   <= '0;
                  r_rdy   <= 1'b1;
                  r_state <= ST_EMPTY;
               end else if (w_pop) begin
                  r_sr    <= w_sr_shift;
                  r_cnt   <= r_cnt - c_W_CNT'(1);
               end
            end
            default: begin
               r_sr    <= '0;
               r_cnt   <= '0;
               r_rdy   <= 1'b1;
               r_state <= ST_EMPTY;
            end
         endcase
      end
   end

   // Sticky overflow: a refused capture wins over a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (dat_vld && !r_rdy) begin
         r_ovf <= 1'b1;
      end else if (w_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign dat_rdy = r_rdy;
   assign reg_out = r_sr[c_W_REG-1:0];
   assign sts_out = pack_status(r_cnt, (r_state == ST_EMPTY), r_ovf);

endmodule

`default_nettype wire

// File: tb/tb_rtmq_input_sr.sv
// ============================================================================
//  Module   : tb_rtmq_input_sr
//  Purpose  : Self-checking bench for rtmq_input_sr (W_REG=32, N_SRL=3) with
//             a queue-based reference model of the words awaiting the CPU.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rtmq_input_sr;
   import rtmq_input_sr_pkg::*;

   localparam int N    = 3;
   localparam int ADDR = 0;
   localparam int WI   = 32 * N;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [c_W_ALU-1:0] alu_out = '0;
   logic [WI-1:0]      dat_inp = '0;
   logic               dat_vld = 1'b0;
   logic               dat_rdy;
   logic [31:0]        reg_out;
   logic [31:0]        sts_out;

   int checks   = 0;
   int failures = 0;

   // Reference model: words still to be read by the CPU, front = current word
   logic [31:0] q[$];
   logic        m_ovf = 1'b0;
   logic        m_trg = 1'b0;
   logic [2:0]  m_cmd = 3'd0;

   always #5 clk = ~clk;

   rtmq_input_sr #(
      .ADDR    (ADDR),
      .N_SRL   (N)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .alu_out (alu_out),
      .dat_inp (dat_inp),
      .dat_vld (dat_vld),
      .dat_rdy (dat_rdy),
      .reg_out (reg_out),
      .sts_out (sts_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [31:0] e_reg;
      logic [31:0] e_sts;
      e_reg = (q.size() == 0) ? 32'd0 : q[0];
      e_sts = {22'd0, m_ovf, (q.size() == 0), 8'(q.size())};
      chk({tag, ".rdy"}, 32'(dat_rdy), 32'(q.size() == 0));
      chk({tag, ".reg"}, reg_out, e_reg);
      chk({tag, ".sts"}, sts_out, e_sts);
   endtask

   // Apply the model's view of one clock edge
   task automatic model_edge(input logic vld, input logic [WI-1:0] d,
                             input logic wr, input logic [7:0] addr, input logic [31:0] cmd);
      logic was_empty;
      logic ovf_set;
      was_empty = (q.size() == 0);
      ovf_set   = vld && !was_empty;
      if (was_empty) begin
         if (vld) begin
            for (int i = 0; i < N; i++) q.push_back(d[32*i +: 32]);
         end
      end else if (m_trg && m_cmd[1]) begin
         q.delete();
      end else if (m_trg && m_cmd[0]) begin
         void'(q.pop_front());
      end
      if (ovf_set) m_ovf = 1'b1;
      else if (m_trg && m_cmd[2]) m_ovf = 1'b0;
      m_trg = wr && (addr == 8'(ADDR));
      if (m_trg) m_cmd = cmd[2:0];
   endtask

   task automatic tick(input logic vld, input logic [WI-1:0] d, input logic wr,
                       input logic [7:0] addr, input logic [31:0] cmd, input string tag);
      dat_vld = vld;
      dat_inp = d;
      alu_out = {wr, addr, cmd};
      @(posedge clk);
      model_edge(vld, d, wr, addr, cmd);
      #1;
      dat_vld = 1'b0;
      alu_out = '0;
      check_model(tag);
   endtask

   task automatic idle(input string tag);
      tick(1'b0, '0, 1'b0, 8'd0, 32'd0, tag);
   endtask

   task automatic wcmd(input logic [31:0] cmd, input string tag);
      tick(1'b0, '0, 1'b1, 8'(ADDR), cmd, tag);
   endtask

   task automatic capture(input logic [WI-1:0] d, input string tag);
      tick(1'b1, d, 1'b0, 8'd0, 32'd0, tag);
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0;
      m_trg = 1'b0;
      m_cmd = 3'd0;
   endtask

   logic [WI-1:0] d_a;
   logic [WI-1:0] d_b;
   logic [WI-1:0] d_r;
   logic [31:0]   rnd;
   logic [31:0]   rcmd;

   initial begin
      d_a = 96'hCCCC_0003_BBBB_0002_AAAA_0001;
      d_b = 96'h3333_3333_2222_2222_1111_1111;

      // Reset state while rst_n is held low
      #12;
      chk("reset.rdy", 32'(dat_rdy), 32'd1);
      chk("reset.reg", reg_out, 32'd0);
      chk("reset.sts", sts_out, 32'h0000_0100);
      @(negedge clk);
      rst_n = 1'b1;
      idle("post_reset");

      // Capture and drain LSW first
      capture(d_a, "cap");
      chk("cap.word0", reg_out, 32'hAAAA_0001);
      chk("cap.cnt3", sts_out, 32'h0000_0003);
      wcmd(32'd1, "pop1.wr");
      chk("pop1.latency", reg_out, 32'hAAAA_0001);
      idle("pop1");
      chk("pop1.word1", reg_out, 32'hBBBB_0002);
      chk("pop1.cnt2", sts_out, 32'h0000_0002);
      wcmd(32'd1, "pop2.wr");
      idle("pop2");
      chk("pop2.word2", reg_out, 32'hCCCC_0003);
      chk("pop2.cnt1", sts_out, 32'h0000_0001);
      wcmd(32'd1, "pop3.wr");
      idle("pop3");
      chk("pop3.reg0", reg_out, 32'd0);
      chk("pop3.empty", sts_out, 32'h0000_0100);
      chk("pop3.rdy", 32'(dat_rdy), 32'd1);

      // Overflow while loaded, then clear
      capture(d_b, "ovf.cap");
      capture(d_a, "ovf.refused");
      chk("ovf.set", sts_out, 32'h0000_0203);
      chk("ovf.sr_kept", reg_out, 32'h1111_1111);
      wcmd(32'd4, "ovf.clr.wr");
      idle("ovf.clr");
      chk("ovf.cleared", sts_out, 32'h0000_0003);

      // POP|FLUSH together: flush wins
      wcmd(32'd3, "popflush.wr");
      idle("popflush");
      chk("popflush.cnt0", sts_out, 32'h0000_0100);

      // POP while empty does nothing
      wcmd(32'd1, "pop_empty.wr");
      idle("pop_empty");
      chk("pop_empty.cnt0", sts_out, 32'h0000_0100);

      // Last POP coinciding with dat_vld: refused, accepted one cycle later
      capture(d_a, "last.cap");
      wcmd(32'd1, "last.p1");
      idle("last.p1i");
      wcmd(32'd1, "last.p2");
      idle("last.p2i");
      wcmd(32'd1, "last.p3");
      capture(d_b, "last.coincide");
      chk("last.ovf_empty", sts_out, 32'h0000_0300);
      capture(d_b, "last.accept");
      chk("last.cnt3", sts_out, 32'h0000_0203);
      chk("last.word0", reg_out, 32'h1111_1111);
      wcmd(32'd4, "last.clr");
      idle("last.clri");

      // Write to the wrong address is ignored
      tick(1'b0, '0, 1'b1, 8'(ADDR + 1), 32'd1, "wrong_addr.wr");
      idle("wrong_addr");
      chk("wrong_addr.sts", sts_out, 32'h0000_0003);
      chk("wrong_addr.reg", reg_out, 32'h1111_1111);

      // Asynchronous reset in the middle of LOADED
      capture(d_a, "arst.setup");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst.rdy", 32'(dat_rdy), 32'd1);
      chk("arst.reg", reg_out, 32'd0);
      chk("arst.sts", sts_out, 32'h0000_0100);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle("arst.release");

      // Randomized traffic against the queue model
      for (int n = 0; n < 600; n++) begin
         rnd  = $urandom;
         rcmd = $urandom;
         d_r  = {$urandom, $urandom, $urandom};
         case (rnd[2:0])
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: rcmd[2:0] = 3'd1;
            3'd5:                          rcmd[2:0] = 3'd2;
            3'd6:                          rcmd[2:0] = 3'd4;
            default:                       rcmd[2:0] = rnd[10:8];
         endcase
         tick((rnd[5:4] == 2'd0), d_r, (rnd[7:6] != 2'd0),
              (rnd[13:12] == 2'd0) ? 8'(ADDR + 1) : 8'(ADDR), rcmd, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
